gray_count_decoder: RTL and testbench

- Receive-side companion to the team's Gray-code counter.
- Samples a WIDTH-bit Gray count from a same-clock producer, decodes it to binary and checks that each new sample is a legal successor of the previous one.
- Reports wrap-arounds and keeps saturating step and error statistics.
- Used wherever a Gray count crosses a block boundary (pointer exchange, position tracking) and the consumer needs binary plus integrity checking.

---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_to_bin.sv | 14 +
 rtl/gray_count_decoder.sv | 130 +++++++++++++
 tb/tb_gray_count_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-count producer/consumer pair: decoder FSM
// states and a width-generic Gray-to-binary helper for checkers.
package gray_pkg;

  // Widest count the helper function can decode.
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_LOCKED = 2'd1,
    S_FAULT  = 2'd2
  } state_e;

  // Decodes the low 'width' bits of a Gray value; upper result bits are zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] gray,
    input int unsigned           width
  );
    logic [GRAY_MAX_W-1:0] bin;
    logic                  acc;
    bin = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < int'(width)) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Pure combinational Gray-to-binary decoder.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit and every more-significant Gray bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_count_decoder.sv
// Receive side of a same-clock Gray count: two-stage decode pipeline, successor
// checking (hold / +1 / wrap / illegal), lock FSM and saturating statistics.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int STEP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      gray_in,
  input  logic                  gray_valid,
  input  logic                  err_clr,
  output logic [WIDTH-1:0]      bin_count,
  output logic                  out_valid,
  output logic                  hold,
  output logic                  wrap_pulse,
  output logic                  step_err,
  output logic                  locked,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  localparam logic [WIDTH-1:0]      BIN_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = '1;
  localparam logic [STEP_CNT_W-1:0] STEP_MAX = '1;

  logic [WIDTH-1:0] s1_gray;
  logic             s1_vld;
  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] diff;

  state_e state_q, state_d;
  logic   hold_d, wrap_d, err_d, step_d;

  // Stage 1 valid: tracks whether s1_gray holds a sample to process.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= gray_valid;
  end

  // Stage 1 data: capture the producer's count when it is flagged valid.
  // NOTE: data is not reset; s1_vld qualifies it, so its post-reset contents never matter.
  always_ff @(posedge clk) begin
    if (gray_valid) s1_gray <= gray_in;
  end

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (s1_gray),
    .bin  (dec_bin)
  );

  // Modulo-2^WIDTH distance from the last accepted value.
  assign diff = dec_bin - bin_count;

  // Next-state and classification of the sample leaving stage 1.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    step_d  = 1'b0;
    if (err_clr) begin
      // A sample arriving alongside the clear becomes the new reference.
      state_d = s1_vld ? S_LOCKED : S_INIT;
    end else if (s1_vld) begin
      unique case (state_q)
        S_INIT: state_d = S_LOCKED;
        S_LOCKED, S_FAULT: begin
          if (diff == '0) begin
            hold_d  = 1'b1;
            state_d = S_LOCKED;
          end else if (diff == WIDTH'(1)) begin
            step_d  = 1'b1;
            wrap_d  = (bin_count == BIN_MAX);
            state_d = S_LOCKED;
          end else begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  assign locked = (state_q == S_LOCKED);

  // Stage 2: registered outputs, pulses and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_count  <= '0;
      out_valid  <= 1'b0;
      hold       <= 1'b0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      step_cnt   <= '0;
    end else begin
      out_valid  <= s1_vld;
      hold       <= hold_d;
      wrap_pulse <= wrap_d;
      step_err   <= err_d;
      if (s1_vld) bin_count <= dec_bin;
      if (err_clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
        step_cnt   <= '0;
      end else begin
        if (err_d) begin
          err_sticky <= 1'b1;
          if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
        if (step_d && (step_cnt != STEP_MAX)) step_cnt <= step_cnt + STEP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Self-checking bench for gray_count_decoder (WIDTH=4): directed vector table
// followed by randomized traffic against a behavioural model.
module tb_gray_count_decoder;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  gray_in;
  logic          gray_valid;
  logic          err_clr;
  logic [W-1:0]  bin_count;
  logic          out_valid, hold, wrap_pulse, step_err, locked, err_sticky;
  logic [7:0]    err_cnt;
  logic [15:0]   step_cnt;

  gray_count_decoder #(.WIDTH(W), .ERR_CNT_W(8), .STEP_CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .gray_valid (gray_valid),
    .err_clr    (err_clr),
    .bin_count  (bin_count),
    .out_valid  (out_valid),
    .hold       (hold),
    .wrap_pulse (wrap_pulse),
    .step_err   (step_err),
    .locked     (locked),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ov;
    logic [3:0]  bin;
    logic        hold;
    logic        wrap;
    logic        err;
    logic        lk;
    logic        st;
    logic [7:0]  ec;
    logic [15:0] sc;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [3:0] gray;
    logic       clr;
    out_t       exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  bit m_s1_vld;
  int m_s1_gray;
  bit m_have_ref, m_fault, m_sticky;
  int m_bin, m_err, m_step;
  bit m_ov, m_hold, m_wrap, m_serr;

  function automatic int to_bin(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  // Advance the model by one clock edge with the inputs applied at that edge.
  function automatic void model_edge(input bit r, input bit v, input int g, input bit c);
    int b, d;
    m_ov = 0; m_hold = 0; m_wrap = 0; m_serr = 0;
    if (r) begin
      m_s1_vld = 0; m_have_ref = 0; m_fault = 0; m_sticky = 0;
      m_bin = 0; m_err = 0; m_step = 0;
      return;
    end
    if (c) begin
      m_err = 0; m_step = 0; m_sticky = 0; m_have_ref = 0; m_fault = 0;
    end
    if (m_s1_vld) begin
      b = to_bin(m_s1_gray);
      m_ov = 1;
      if (m_have_ref) begin
        d = ((b - m_bin) % MOD + MOD) % MOD;
        if (d == 0) begin
          m_hold = 1; m_fault = 0;
        end else if (d == 1) begin
          m_wrap = (m_bin == MOD - 1);
          if (m_step < 65535) m_step++;
          m_fault = 0;
        end else begin
          m_serr = 1; m_sticky = 1; m_fault = 1;
          if (m_err < 255) m_err++;
        end
      end
      m_have_ref = 1;
      m_bin = b;
    end
    m_s1_vld  = v;
    m_s1_gray = g;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.ov = m_ov; o.bin = 4'(m_bin); o.hold = m_hold; o.wrap = m_wrap; o.err = m_serr;
    o.lk = m_have_ref && !m_fault; o.st = m_sticky; o.ec = 8'(m_err); o.sc = 16'(m_step);
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input out_t e);
    check({tag, ".out_valid"},  32'(out_valid),  32'(e.ov));
    check({tag, ".bin_count"},  32'(bin_count),  32'(e.bin));
    check({tag, ".hold"},       32'(hold),       32'(e.hold));
    check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(e.wrap));
    check({tag, ".step_err"},   32'(step_err),   32'(e.err));
    check({tag, ".locked"},     32'(locked),     32'(e.lk));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(e.st));
    check({tag, ".err_cnt"},    32'(err_cnt),    32'(e.ec));
    check({tag, ".step_cnt"},   32'(step_cnt),   32'(e.sc));
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, settle.
  task automatic step(input logic r, input logic v, input logic [3:0] g, input logic c);
    rst = r; gray_valid = v; gray_in = g; err_clr = c;
    @(posedge clk);
    model_edge(r, v, int'(g), c);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] g, input logic c,
                              input logic ov, input int bin, input logic h, input logic w,
                              input logic e, input logic lk, input logic st,
                              input int ec, input int sc);
    vec_t t;
    t.rst = r; t.vld = v; t.gray = g; t.clr = c;
    t.exp.ov = ov; t.exp.bin = 4'(bin); t.exp.hold = h; t.exp.wrap = w; t.exp.err = e;
    t.exp.lk = lk; t.exp.st = st; t.exp.ec = 8'(ec); t.exp.sc = 16'(sc);
    return t;
  endfunction

  vec_t tbl [28];

  initial begin
    int prod;
    logic r, v, c;

    // Expected outputs are those visible just after each row's clock edge;
    // a sample driven on row k appears on row k+1.
    //             rst v  gray    clr  ov bin h  w  e  lk st ec sc
    tbl[0]  = mk(1, 1, 4'b0101, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0); // reset, valid toggling
    tbl[1]  = mk(1, 1, 4'b0011, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 4'b0000, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0); // in-flight sample dropped
    tbl[3]  = mk(0, 1, 4'b0000, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0); // legal count 0..3
    tbl[4]  = mk(0, 1, 4'b0001, 0,  1, 0,  0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 4'b0011, 0,  1, 1,  0, 0, 0, 1, 0, 0, 1);
    tbl[6]  = mk(0, 1, 4'b0010, 0,  1, 2,  0, 0, 0, 1, 0, 0, 2);
    tbl[7]  = mk(0, 0, 4'b0000, 0,  1, 3,  0, 0, 0, 1, 0, 0, 3);
    tbl[8]  = mk(0, 1, 4'b1000, 0,  0, 3,  0, 0, 0, 1, 0, 0, 3); // bin 15
    tbl[9]  = mk(0, 1, 4'b0000, 1,  1, 15, 0, 0, 0, 1, 0, 0, 0); // clear with sample: new ref
    tbl[10] = mk(0, 0, 4'b0000, 0,  1, 0,  0, 1, 0, 1, 0, 0, 1); // wrap 15 -> 0
    tbl[11] = mk(0, 1, 4'b0001, 0,  0, 0,  0, 0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 1, 4'b0010, 0,  1, 1,  0, 0, 0, 1, 0, 0, 2);
    tbl[13] = mk(0, 1, 4'b0110, 0,  1, 3,  0, 0, 1, 0, 1, 1, 2); // 1 -> 3 illegal
    tbl[14] = mk(0, 1, 4'b0011, 0,  1, 4,  0, 0, 0, 1, 1, 1, 3); // 3 -> 4 relocks
    tbl[15] = mk(0, 1, 4'b0001, 0,  1, 2,  0, 0, 1, 0, 1, 2, 3); // 4 -> 2 illegal
    tbl[16] = mk(0, 1, 4'b0011, 0,  1, 1,  0, 0, 1, 0, 1, 3, 3); // 2 -> 1 backward
    tbl[17] = mk(0, 1, 4'b0011, 0,  1, 2,  0, 0, 0, 1, 1, 3, 4);
    tbl[18] = mk(0, 0, 4'b0000, 0,  1, 2,  1, 0, 0, 1, 1, 3, 4); // repeat -> hold
    tbl[19] = mk(0, 0, 4'b0000, 1,  0, 2,  0, 0, 0, 0, 0, 0, 0); // clear, bin held
    tbl[20] = mk(0, 1, 4'b0111, 0,  0, 2,  0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 4'b0000, 0,  1, 5,  0, 0, 0, 1, 0, 0, 0); // reference, no class
    tbl[22] = mk(0, 1, 4'b0100, 0,  0, 5,  0, 0, 0, 1, 0, 0, 0);
    tbl[23] = mk(1, 1, 4'b0101, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0); // reset mid-stream
    tbl[24] = mk(1, 1, 4'b1100, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 4'b0000, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(0, 1, 4'b1100, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(0, 0, 4'b0000, 0,  1, 8,  0, 0, 0, 1, 0, 0, 0); // first sample after reset

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].gray, tbl[i].clr);
      compare($sformatf("row%0d", i), tbl[i].exp);
    end

    // Saturation corner: a long run of alternating illegal jumps drives err_cnt to its ceiling.
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    compare("sat_rst", model_out());
    for (int i = 0; i < 270; i++) begin
      prod = (i % 2 == 0) ? 0 : 8;
      step(1'b0, 1'b1, 4'(prod ^ (prod >> 1)), 1'b0);
    end
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    compare("sat_end", model_out());
    check("sat_err_cnt_ceiling", 32'(err_cnt), 32'd255);

    // Randomized traffic: mostly legal successors, some holds and random jumps.
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    prod = 0;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      prod = (prod + 1) % MOD;
      else if (sel < 6) prod = prod;
      else              prod = int'($urandom_range(0, MOD - 1));
      v = ($urandom_range(0, 3) != 0);
      c = (i >= 1200) && ($urandom_range(0, 63) == 0);
      r = (i >= 1200) && ($urandom_range(0, 299) == 0);
      step(r, v, 4'(prod ^ (prod >> 1)), c);
      compare($sformatf("rnd%0d", i), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
